// File: rtl/main_memory_burst.sv
// Clocked main-memory model for cache line fills and write-backs: request/handshake
// front end, strobed burst writes, fixed access latency and optional critical-word-first wrap.
module main_memory_burst #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int LATENCY    = 4,
    parameter int DEPTH      = 1024,
    parameter int WRAP_BURST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic                    wr_done,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_last
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BYTE_BITS = $clog2(BYTES);
    localparam int BEAT_BITS = $clog2(BURST_LEN);
    localparam int LINE_BITS = BYTE_BITS + BEAT_BITS;
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int WAIT_W    = $clog2(LATENCY + 1);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << LINE_BITS) - 1);
    localparam logic [BEAT_BITS:0]    LAST_BEAT   = (BEAT_BITS + 1)'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST   = WAIT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   line_base;
    logic [BEAT_BITS-1:0]    start_beat;
    logic [BEAT_BITS:0]      beat_cnt;
    logic [WAIT_W-1:0]       wait_cnt;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        written;

    logic                    accept;
    logic                    wr_fire;
    logic                    rd_emit;
    logic                    rd_end;
    logic                    done_pulse;
    logic                    waiting;
    logic [BEAT_BITS-1:0]    beat_sel;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic [IDX_BITS-1:0]     beat_idx;
    logic [DATA_WIDTH-1:0]   stored_val;
    logic [DATA_WIDTH-1:0]   merged;

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == WR_BURST);
    assign accept    = req_valid && req_ready;
    assign wr_fire   = wr_valid && wr_ready;

    // Beat k of a burst targets line_base + ((start + k) mod BURST_LEN) beats; the
    // narrow beat_sel adder supplies the wrap for free.
    assign beat_sel   = start_beat + beat_cnt[BEAT_BITS-1:0];
    assign beat_addr  = line_base | (ADDR_WIDTH'(beat_sel) << BYTE_BITS);
    assign beat_idx   = beat_addr[BYTE_BITS +: IDX_BITS];

    // Never-written entries read back as their own byte address.
    assign stored_val = written[beat_idx] ? mem[beat_idx] : DATA_WIDTH'(beat_addr);

    always_comb begin
        merged = stored_val;
        for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) begin
                merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d    = state;
        rd_emit    = 1'b0;
        rd_end     = 1'b0;
        done_pulse = 1'b0;
        waiting    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = req_we ? WR_BURST : RD_WAIT;
                end
            end
            RD_WAIT: begin
                waiting = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_d = RD_BURST;
                    rd_emit = 1'b1;
                end
            end
            RD_BURST: begin
                if (rd_last) begin
                    state_d = IDLE;
                    rd_end  = 1'b1;
                end else begin
                    rd_emit = 1'b1;
                end
            end
            WR_BURST: begin
                if (wr_fire && (beat_cnt == LAST_BEAT)) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                waiting = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_d    = IDLE;
                    done_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            state      <= IDLE;
            line_base  <= '0;
            start_beat <= '0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            state   <= state_d;
            wr_done <= done_pulse;

            if (accept) begin
                line_base  <= req_addr & ~OFFSET_MASK;
                start_beat <= (WRAP_BURST != 0) ? req_addr[BYTE_BITS +: BEAT_BITS] : '0;
            end

            if (accept) begin
                beat_cnt <= '0;
            end else if (rd_emit || wr_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (state_d != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // rd_data is only loaded on a beat, so it holds between bursts.
            if (rd_emit) begin
                rd_data  <= stored_val;
                rd_valid <= 1'b1;
                rd_last  <= (beat_cnt == LAST_BEAT);
            end else if (rd_end) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

    // Reset clears only the written bits; that alone makes every entry read as default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else if (wr_fire) begin
            written[beat_idx] <= 1'b1;
        end
    end

    // NOTE: the storage array itself is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[beat_idx] <= merged;
        end
    end

endmodule
